// File: rtl/cla_adder.sv
// cla_adder: registered two-level carry-lookahead adder/subtractor.
// 4-bit lookahead groups, group-level lookahead across groups.
module cla_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             mode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic             out_valid
);

    localparam int NG = WIDTH / 4;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [WIDTH:0]   c;

    logic [WIDTH-1:0] sum_d;
    logic             c_out_d;
    logic             ovf_d;

    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;
    logic             ovf_q;
    logic             vld_q;

    assign bx = b ^ {WIDTH{mode}};
    assign g  = a & bx;
    assign p  = a ^ bx;

    // Per-group generate and propagate.
    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < NG; k++) begin
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp[k] = &p[4*k +: 4];
        end
    end

    // Second-level lookahead: each group carry-in as a flat
    // sum-of-products over group G/P terms and c_in.
    always_comb begin
        logic acc;
        logic prod;
        gc    = '0;
        gc[0] = c_in;
        acc   = 1'b0;
        prod  = 1'b1;
        for (int k = 0; k < NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc  = acc | (prod & gg[j]);
                prod = prod & gp[j];
            end
            gc[k+1] = acc | (prod & c_in);
        end
    end

    // In-group carries from the group carry-in, no ripple.
    always_comb begin
        logic c0;
        c    = '0;
        c[0] = c_in;
        c0   = 1'b0;
        for (int k = 0; k < NG; k++) begin
            c0 = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & c0);
            c[4*k+2] = g[4*k+1]
                     | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & c0);
            c[4*k+3] = g[4*k+2]
                     | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c0);
            c[4*k+4] = gc[k+1];
        end
    end

    assign sum_d   = p ^ c[WIDTH-1:0];
    assign c_out_d = c[WIDTH];
    assign ovf_d   = c[WIDTH] ^ c[WIDTH-1];

    // Output registers load every cycle; out_valid tags meaningful data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            vld_q   <= in_valid;
        end
    end

    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign overflow  = ovf_q;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_cla_adder.sv
// tb_cla_adder: directed, exhaustive (WIDTH=4) and random (WIDTH=16)
// checks against an arithmetic reference model.
module tb_cla_adder;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  a4, b4;
    logic        cin4, mode4, iv4;
    logic [3:0]  sum4;
    logic        co4, ov4, ovld4;

    logic [15:0] a16, b16;
    logic        cin16, mode16, iv16;
    logic [15:0] sum16;
    logic        co16, ov16, ovld16;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    cla_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .a(a4), .b(b4), .c_in(cin4), .mode(mode4),
        .in_valid(iv4),
        .sum(sum4), .c_out(co4), .overflow(ov4),
        .out_valid(ovld4)
    );

    cla_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .a(a16), .b(b16), .c_in(cin16), .mode(mode16),
        .in_valid(iv16),
        .sum(sum16), .c_out(co16), .overflow(ov16),
        .out_valid(ovld16)
    );

    task automatic check_eq(input string tag,
                            input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {overflow, c_out, sum[15:0]} for a w-bit operation.
    function automatic logic [17:0] ref_op(input int w,
                                           input logic [15:0] ra,
                                           input logic [15:0] rb,
                                           input logic rcin,
                                           input logic rmode);
        longint mask;
        longint bxv;
        longint full;
        longint s;
        logic   co, sa, sb, ss, ov;
        mask = (longint'(1) << w) - 1;
        bxv  = (rmode ? ~longint'(rb) : longint'(rb)) & mask;
        full = (longint'(ra) & mask) + bxv + longint'(rcin);
        s    = full & mask;
        co   = ((full >> w) & 1) != 0;
        sa   = ((longint'(ra) >> (w-1)) & 1) != 0;
        sb   = ((bxv >> (w-1)) & 1) != 0;
        ss   = ((s >> (w-1)) & 1) != 0;
        ov   = (sa == sb) && (ss != sa);
        return {ov, co, s[15:0]};
    endfunction

    typedef struct {
        logic [3:0] a, b;
        logic       cin, mode;
        logic [3:0] s;
        logic       co, ov;
    } dvec_t;

    dvec_t dtab[5];

    logic [17:0] e4, e16;
    logic        ev4, ev16;

    initial begin
        dtab[0] = '{4'h5, 4'h2, 1'b0, 1'b0, 4'h7, 1'b0, 1'b0};
        dtab[1] = '{4'h5, 4'h2, 1'b1, 1'b1, 4'h3, 1'b1, 1'b0};
        dtab[2] = '{4'hF, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0};
        dtab[3] = '{4'h7, 4'h1, 1'b0, 1'b0, 4'h8, 1'b0, 1'b1};
        dtab[4] = '{4'h2, 4'h5, 1'b1, 1'b1, 4'hD, 1'b0, 1'b0};

        rst_n = 1'b0;
        a4 = '0; b4 = '0; cin4 = 0; mode4 = 0; iv4 = 0;
        a16 = '0; b16 = '0; cin16 = 0; mode16 = 0; iv16 = 0;

        #12;
        check_eq("rst_sum4", 32'(sum4), 0);
        check_eq("rst_vld4", 32'(ovld4), 0);
        check_eq("rst_sum16", 32'(sum16), 0);
        check_eq("rst_vld16", 32'(ovld16), 0);

        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with fixed expectations.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a4 = dtab[i].a; b4 = dtab[i].b;
            cin4 = dtab[i].cin; mode4 = dtab[i].mode;
            iv4 = 1'b1;
            @(posedge clk);
            #1;
            check_eq($sformatf("dir%0d_sum", i), 32'(sum4), 32'(dtab[i].s));
            check_eq($sformatf("dir%0d_co", i), 32'(co4), 32'(dtab[i].co));
            check_eq($sformatf("dir%0d_ov", i), 32'(ov4), 32'(dtab[i].ov));
            check_eq($sformatf("dir%0d_vld", i), 32'(ovld4), 1);
        end

        // Reset asserted between edges while outputs are nonzero.
        check_eq("pre_rst_sum", 32'(sum4), 32'hD);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_sum4", 32'(sum4), 0);
        check_eq("async_co4", 32'(co4), 0);
        check_eq("async_ov4", 32'(ov4), 0);
        check_eq("async_vld4", 32'(ovld4), 0);
        check_eq("async_vld16", 32'(ovld16), 0);
        @(posedge clk);
        #1;
        check_eq("held_vld4", 32'(ovld4), 0);
        check_eq("held_sum4", 32'(sum4), 0);
        @(negedge clk);
        rst_n = 1'b1;
        a4 = 4'h5; b4 = 4'h2; cin4 = 0; mode4 = 0; iv4 = 1;
        @(posedge clk);
        #1;
        check_eq("post_rst_vld", 32'(ovld4), 1);
        check_eq("post_rst_sum", 32'(sum4), 7);

        // Exhaustive WIDTH=4, random WIDTH=16 in parallel, back to back.
        for (int k = 0; k < 1024; k++) begin
            @(negedge clk);
            {mode4, cin4, a4, b4} = 10'(k);
            iv4    = 1'($urandom_range(0, 1));
            a16    = 16'($urandom);
            b16    = 16'($urandom);
            cin16  = 1'($urandom_range(0, 1));
            mode16 = 1'($urandom_range(0, 1));
            iv16   = 1'($urandom_range(0, 1));
            e4   = ref_op(4, {12'b0, a4}, {12'b0, b4}, cin4, mode4);
            e16  = ref_op(16, a16, b16, cin16, mode16);
            ev4  = iv4;
            ev16 = iv16;
            @(posedge clk);
            #1;
            check_eq("ex_sum4", 32'(sum4), 32'(e4[3:0]));
            check_eq("ex_co4", 32'(co4), 32'(e4[16]));
            check_eq("ex_ov4", 32'(ov4), 32'(e4[17]));
            check_eq("ex_vld4", 32'(ovld4), 32'(ev4));
            check_eq("rnd_sum16", 32'(sum16), 32'(e16[15:0]));
            check_eq("rnd_co16", 32'(co16), 32'(e16[16]));
            check_eq("rnd_ov16", 32'(ov16), 32'(e16[17]));
            check_eq("rnd_vld16", 32'(ovld16), 32'(ev16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
